video_timing: RTL

VIDEO_TIMING -- requirements
Module: video_timing

---
 rtl/gpu_timing_pkg.sv | 52 +++++
 rtl/timing_axis_counter.sv | 53 +++++
 rtl/video_timing.sv | 119 +++++++++++
 3 files changed

// File: rtl/gpu_timing_pkg.sv
// Raster timing shared by the GPU stages: region boundaries, default frame geometry,
// output widths and the visible game-area size.
package gpu_timing_pkg;

   localparam int X_W     = 9;
   localparam int Y_W     = 9;
   localparam int V_W     = 10;
   localparam int FRAME_W = 8;

   // Horizontal line in gpu_clk cycles: active, front porch, sync, back porch.
   localparam int H_ACTIVE_DEF     = 320;
   localparam int H_FRONT_LEN      = 8;
   localparam int H_SYNC_LEN       = 48;
   localparam int H_BACK_LEN       = 24;
   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FRONT_LEN;
   localparam int H_SYNC_LAST_DEF  = H_SYNC_START_DEF + H_SYNC_LEN - 1;
   localparam int H_TOTAL_DEF      = H_SYNC_START_DEF + H_SYNC_LEN + H_BACK_LEN;

   // Vertical frame in physical lines; vblank begins at the first front-porch line.
   localparam int V_ACTIVE_DEF     = 480;
   localparam int V_FRONT_LEN      = 10;
   localparam int V_SYNC_LEN       = 2;
   localparam int V_BACK_LEN       = 33;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FRONT_LEN;
   localparam int V_SYNC_LAST_DEF  = V_SYNC_START_DEF + V_SYNC_LEN - 1;
   localparam int V_TOTAL_DEF      = V_SYNC_START_DEF + V_SYNC_LEN + V_BACK_LEN;

   localparam int GAME_W_DEF = 256;
   localparam int GAME_H_DEF = 240;

   typedef enum logic [1:0] {
      REGION_ACTIVE,
      REGION_FRONT,
      REGION_SYNC,
      REGION_BACK
   } region_e;

   function automatic region_e region_of(input int pos, input int active,
                                         input int sync_start, input int sync_last);
      region_e region;
      if (pos < active)
         region = REGION_ACTIVE;
      else if (pos < sync_start)
         region = REGION_FRONT;
      else if (pos <= sync_last)
         region = REGION_SYNC;
      else
         region = REGION_BACK;
      return region;
   endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter with a terminal-count strobe and a
// registered active-low sync flag that always matches the registered count.
module timing_axis_counter
   import gpu_timing_pkg::*;
#(
   parameter int WIDTH      = X_W,
   parameter int TOTAL      = H_TOTAL_DEF,
   parameter int ACTIVE     = H_ACTIVE_DEF,
   parameter int SYNC_START = H_SYNC_START_DEF,
   parameter int SYNC_LAST  = H_SYNC_LAST_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_advance,
   output logic [WIDTH-1:0] o_count,
   output logic [WIDTH-1:0] o_count_next,
   output logic             o_terminal,
   output logic             o_sync_n
);

   localparam logic [WIDTH-1:0] L_LAST = WIDTH'(TOTAL - 1);

   logic [WIDTH-1:0] r_count;
   logic             r_sync_n;
   logic [WIDTH-1:0] w_count_next;
   logic             w_at_last;

   assign w_at_last  = (r_count == L_LAST);
   assign o_terminal = i_advance && w_at_last;

   always_comb begin
      w_count_next = r_count;
      if (i_advance)
         w_count_next = w_at_last ? '0 : r_count + WIDTH'(1);
   end

   // Sync is decoded from the next count so it lands in the same cycle as that count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count  <= '0;
         r_sync_n <= 1'b1;
      end else begin
         r_count  <= w_count_next;
         r_sync_n <= (region_of(int'(w_count_next), ACTIVE, SYNC_START, SYNC_LAST)
                      != REGION_SYNC);
      end
   end

   assign o_count      = r_count;
   assign o_count_next = w_count_next;
   assign o_sync_n     = r_sync_n;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator for the GPU: pixel/line counters, syncs, game-area visible
// flag, vblank interrupt with CPU acknowledge, and a completed-frame counter.
module video_timing
   import gpu_timing_pkg::*;
#(
   parameter int LINE_REPEAT  = 2,
   parameter int H_TOTAL      = H_TOTAL_DEF,
   parameter int V_TOTAL      = V_TOTAL_DEF,
   parameter int H_ACTIVE     = H_ACTIVE_DEF,
   parameter int H_SYNC_START = H_SYNC_START_DEF,
   parameter int H_SYNC_LAST  = H_SYNC_LAST_DEF,
   parameter int V_ACTIVE     = V_ACTIVE_DEF,
   parameter int V_SYNC_START = V_SYNC_START_DEF,
   parameter int V_SYNC_LAST  = V_SYNC_LAST_DEF,
   parameter int GAME_W       = GAME_W_DEF,
   parameter int GAME_H       = GAME_H_DEF
) (
   input  logic               gpu_clk,
   input  logic               rst,
   input  logic               irq_ack,
   output logic [X_W-1:0]     current_x,
   output logic [Y_W-1:0]     current_y,
   output logic               hsync,
   output logic               vsync,
   output logic               visible,
   output logic               vblank_irq,
   output logic [FRAME_W-1:0] frame_count
);

   if (LINE_REPEAT < 2) begin : g_bad_line_repeat
      $error("video_timing: LINE_REPEAT must be at least 2");
   end

   localparam logic [V_W-1:0] L_IRQ_LINE = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] L_REPEAT   = V_W'(LINE_REPEAT);
   localparam logic [X_W-1:0] L_GAME_W   = X_W'(GAME_W);
   localparam logic [Y_W-1:0] L_GAME_H   = Y_W'(GAME_H);

   logic [X_W-1:0]     w_hcount;
   logic [X_W-1:0]     w_hcount_next;
   logic [V_W-1:0]     w_vcount;
   logic [V_W-1:0]     w_vcount_next;
   logic               w_line_end;
   logic               w_frame_end;
   logic               w_hsync_n;
   logic               w_vsync_n;
   logic [Y_W-1:0]     w_row_next;
   logic               w_irq_set;

   logic [Y_W-1:0]     r_current_y;
   logic               r_visible;
   logic               r_vblank_irq;
   logic [FRAME_W-1:0] r_frame_count;

   timing_axis_counter #(
      .WIDTH      (X_W),
      .TOTAL      (H_TOTAL),
      .ACTIVE     (H_ACTIVE),
      .SYNC_START (H_SYNC_START),
      .SYNC_LAST  (H_SYNC_LAST)
   ) u_h_axis (
      .i_clk        (gpu_clk),
      .i_rst_n      (rst),
      .i_advance    (1'b1),
      .o_count      (w_hcount),
      .o_count_next (w_hcount_next),
      .o_terminal   (w_line_end),
      .o_sync_n     (w_hsync_n)
   );

   timing_axis_counter #(
      .WIDTH      (V_W),
      .TOTAL      (V_TOTAL),
      .ACTIVE     (V_ACTIVE),
      .SYNC_START (V_SYNC_START),
      .SYNC_LAST  (V_SYNC_LAST)
   ) u_v_axis (
      .i_clk        (gpu_clk),
      .i_rst_n      (rst),
      .i_advance    (w_line_end),
      .o_count      (w_vcount),
      .o_count_next (w_vcount_next),
      .o_terminal   (w_frame_end),
      .o_sync_n     (w_vsync_n)
   );

   assign w_row_next = Y_W'(w_vcount_next / L_REPEAT);

   // The set fires while the counters sit at the first vblank position, so an ack
   // sampled on that same edge loses to it.
   assign w_irq_set = (w_vcount == L_IRQ_LINE) && (w_hcount == '0);

   always_ff @(posedge gpu_clk or negedge rst) begin
      if (!rst) begin
         r_current_y   <= '0;
         r_visible     <= 1'b1;
         r_vblank_irq  <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_current_y <= w_row_next;
         r_visible   <= (w_hcount_next < L_GAME_W) && (w_row_next < L_GAME_H);
         if (w_irq_set)
            r_vblank_irq <= 1'b1;
         else if (irq_ack)
            r_vblank_irq <= 1'b0;
         if (w_frame_end)
            r_frame_count <= r_frame_count + FRAME_W'(1);
      end
   end

   assign current_x   = w_hcount;
   assign current_y   = r_current_y;
   assign hsync       = w_hsync_n;
   assign vsync       = w_vsync_n;
   assign visible     = r_visible;
   assign vblank_irq  = r_vblank_irq;
   assign frame_count = r_frame_count;

endmodule
